enoc_switch_allocator: RTL

// - Router stage directly downstream of the per-input route calculators.
// - Consumes each input port's one-hot [c,n,e,s,w] output request and arbitrates every output port among the

---
 rtl/enoc_switch_allocator_pkg.sv | 30 +++
 rtl/enoc_switch_allocator_if.sv | 30 +++
 rtl/enoc_rr_arbiter.sv | 70 +++++++
 rtl/enoc_switch_allocator.sv | 63 ++++++
 4 files changed

// File: rtl/enoc_switch_allocator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enoc_switch_allocator_pkg
// Description : Shared ENoC definitions: port indices, request vector type
//               and the log2 helper used to size pointers.
// Revision    : 1.0 - initial release
// ============================================================================
package enoc_switch_allocator_pkg;

  // Ceiling log2, used for pointer / owner index widths.
  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int NUM_PORTS = 5;

  // Port order [c,n,e,s,w]; index 0 is the local port.
  localparam int C = 0;
  localparam int N = 1;
  localparam int E = 2;
  localparam int S = 3;
  localparam int W = 4;

  typedef logic [0:NUM_PORTS-1] port_req_t;

endpackage
`default_nettype wire

// File: rtl/enoc_switch_allocator_if.sv
`default_nettype none
// ============================================================================
// Module      : enoc_switch_allocator_if
// Description : Request / grant bundle between the route calculators and
//               buffers (master) and the switch allocator (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface enoc_switch_allocator_if
  import enoc_switch_allocator_pkg::*;
#(
  parameter int PORTS = NUM_PORTS
);
  logic [0:PORTS-1][0:PORTS-1] i_output_req;    // [in][out]
  logic [0:PORTS-1]            i_tail;
  logic [0:PORTS-1]            i_en;
  logic [0:PORTS-1][0:PORTS-1] o_output_grant;  // [out][in]
  logic [0:PORTS-1]            o_output_val;
  logic [0:PORTS-1]            o_input_grant;

  modport master (
    output i_output_req, i_tail, i_en,
    input  o_output_grant, o_output_val, o_input_grant
  );

  modport slave (
    input  i_output_req, i_tail, i_en,
    output o_output_grant, o_output_val, o_input_grant
  );
endinterface
`default_nettype wire

// File: rtl/enoc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : enoc_rr_arbiter
// Description : Per-output round-robin arbiter with packet lock. Holds the
//               output for one input from its first granted flit to its tail.
// Revision    : 1.0 - initial release
// ============================================================================
module enoc_rr_arbiter
  import enoc_switch_allocator_pkg::*;
#(
  parameter int PORTS = NUM_PORTS
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic [0:PORTS-1] i_req,
  input  wire logic [0:PORTS-1] i_tail,
  input  wire logic             i_en,
  output logic      [0:PORTS-1] o_grant
);
  localparam int PTR_W = log2(PORTS);

  logic             lock;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] ptr;
  logic             found;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] next_ptr;

  // Pick the winner: locked owner, or first requester scanning from ptr.
  always_comb begin
    found   = 1'b0;
    winner  = owner;
    o_grant = '0;
    if (lock) begin
      found = i_req[owner];
    end else begin
      for (int k = 0; k < PORTS; k++) begin
        if (!found && i_req[(int'(ptr) + k) % PORTS]) begin
          found  = 1'b1;
          winner = PTR_W'((int'(ptr) + k) % PORTS);
        end
      end
    end
    // No downstream space or reset held: nothing moves, outputs stay zero.
    found = found & i_en & reset_n;
    for (int i = 0; i < PORTS; i++) begin
      o_grant[i] = found && (int'(winner) == i);
    end
    next_ptr = (int'(winner) == PORTS - 1) ? '0 : winner + 1'b1;
  end

  // Lock on a head/body grant; unlock and advance the pointer on a tail grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock  <= 1'b0;
      owner <= '0;
      ptr   <= '0;
    end else if (found) begin
      if (i_tail[winner]) begin
        lock <= 1'b0;
        ptr  <= next_ptr;
      end else begin
        lock  <= 1'b1;
        owner <= winner;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/enoc_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : enoc_switch_allocator
// Description : Router switch allocator. Masks malformed requests, transposes
//               [in][out] requests to per-output arbiters and OR-reduces the
//               grants into output-valid and input-dequeue strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module enoc_switch_allocator
  import enoc_switch_allocator_pkg::*;
#(
  parameter int PORTS = NUM_PORTS
) (
  input wire logic                 clk,
  input wire logic                 reset_n,
  enoc_switch_allocator_if.slave   bus
);
  logic [0:PORTS-1][0:PORTS-1] req_by_out;  // [out][in], masked
  logic [0:PORTS-1][0:PORTS-1] grant;       // [out][in]

  // Drop any input whose request is not exactly one-hot, then transpose.
  always_comb begin
    req_by_out = '0;
    for (int i = 0; i < PORTS; i++) begin
      logic [0:PORTS-1] r;
      logic             one_hot;
      r       = bus.i_output_req[i];
      one_hot = (r != '0) && ((r & (r - 1'b1)) == '0);
      for (int o = 0; o < PORTS; o++) begin
        req_by_out[o][i] = one_hot & r[o];
      end
    end
  end

  generate
    for (genvar o = 0; o < PORTS; o++) begin : g_out_arb
      enoc_rr_arbiter #(
        .PORTS (PORTS)
      ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   (req_by_out[o]),
        .i_tail  (bus.i_tail),
        .i_en    (bus.i_en[o]),
        .o_grant (grant[o])
      );
    end
  endgenerate

  // Crossbar selects plus per-output valid and per-input dequeue reductions.
  always_comb begin
    bus.o_output_grant = grant;
    bus.o_input_grant  = '0;
    for (int o = 0; o < PORTS; o++) begin
      bus.o_output_val[o] = |grant[o];
      for (int i = 0; i < PORTS; i++) begin
        bus.o_input_grant[i] = bus.o_input_grant[i] | grant[o][i];
      end
    end
  end

endmodule
`default_nettype wire
